// File: rtl/vga_stream_gen_if.sv
// strVGA stream bundle: enable flows toward the generator, the stream word and frame tick flow out.
// No storage of its own; timing is set entirely by the generator.
// enable is the only backpressure: when it is low the source holds its word.
interface vga_stream_gen_if;
  logic        enable;
  logic [22:0] strVGA;
  logic        frame_tick;

  modport master (
    input  enable,
    output strVGA,
    output frame_tick
  );

  modport slave (
    output enable,
    input  strVGA,
    input  frame_tick
  );
endinterface

// File: rtl/vga_stream_gen.sv
// Free-running VGA raster generator producing the 23-bit strVGA word plus an end-of-frame tick.
// Latency 1: the word for counter state (hc,vc) is registered on the edge that advances past it.
// enable low freezes counters and the word; frame_tick is forced low so a stall never repeats it.
module vga_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic             px_clk,
  input  logic             reset,
  vga_stream_gen_if.master stream
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter end values fit 10 bits because both totals are limited to 1024.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits so a sync pulse ending exactly at 1024 still compares correctly.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Word shown while held in reset: origin, blanked, both syncs at their idle level.
  localparam logic [22:0] RESET_WORD = {10'd0, 10'd0, 1'b0, ~HS_POL, ~VS_POL};

  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [10:0] hc_w;
  logic [10:0] vc_w;
  logic        h_last;
  logic        v_last;
  logic        active;
  logic        hsync;
  logic        vsync;

  // Decode the current counter state into the fields of the next stream word.
  always_comb begin
    hc_w   = {1'b0, hc};
    vc_w   = {1'b0, vc};
    h_last = (hc == H_LAST);
    v_last = (vc == V_LAST);
    active = (hc_w < H_ACT_END) && (vc_w < V_ACT_END);
    hsync  = ((hc_w >= HS_START) && (hc_w < HS_END)) ? HS_POL : ~HS_POL;
    vsync  = ((vc_w >= VS_START) && (vc_w < VS_END)) ? VS_POL : ~VS_POL;
  end

  // Register the decoded word together with the counters so all fields stay aligned.
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      hc                <= 10'd0;
      vc                <= 10'd0;
      stream.strVGA     <= RESET_WORD;
      stream.frame_tick <= 1'b0;
    end else if (stream.enable) begin
      stream.strVGA     <= {hc, vc, active, hsync, vsync};
      stream.frame_tick <= h_last && v_last;
      if (h_last) begin
        hc <= 10'd0;
        vc <= v_last ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end else begin
      stream.frame_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_stream_gen.sv
// Directed bench: a full-size 640x480 instance for line timing, stalls and async reset,
// plus a reduced-raster instance (16x11, active-high hsync) for frame wrap and tick period.
module tb_vga_stream_gen;

  logic px_clk = 1'b0;
  logic reset  = 1'b0;

  always #5 px_clk = ~px_clk;

  vga_stream_gen_if a_if ();
  vga_stream_gen_if b_if ();

  vga_stream_gen dut_a (
    .px_clk (px_clk),
    .reset  (reset),
    .stream (a_if)
  );

  vga_stream_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) dut_b (
    .px_clk (px_clk),
    .reset  (reset),
    .stream (b_if)
  );

  localparam logic [22:0] A_RST = 23'h000003;
  localparam logic [22:0] B_RST = 23'h000001;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference raster positions: the (x,y) each instance should emit on its next enabled edge.
  int ax = 0, ay = 0, bx = 0, by = 0;
  logic [22:0] last_a = A_RST;
  logic [22:0] last_b = B_RST;

  int a_act_cnt = 0, a_hsl_cnt = 0;
  int b_act_cnt = 0, b_vsl_cnt = 0;
  int b_ticks = 0, b_last_tick = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 640x480 timing: hsync low for x 656..751, vsync low for y 490..491.
  function automatic logic [22:0] word_a(input int x, input int y);
    logic act, hs, vs;
    act = (x < 640) && (y < 480);
    hs  = !((x >= 656) && (x < 752));
    vs  = !((y >= 490) && (y < 492));
    return {10'(x), 10'(y), act, hs, vs};
  endfunction

  // Reduced raster: hsync high for x 10..12, vsync low for y 7..8.
  function automatic logic [22:0] word_b(input int x, input int y);
    logic act, hs, vs;
    act = (x < 8) && (y < 6);
    hs  = (x >= 10) && (x < 13);
    vs  = !((y >= 7) && (y < 9));
    return {10'(x), 10'(y), act, hs, vs};
  endfunction

  // One clock: sample 1 ns after the edge and compare both instances to the reference raster.
  task automatic cycle();
    logic ea, eb, rs;
    logic [22:0] exp;
    ea = a_if.enable;
    eb = b_if.enable;
    rs = reset;
    @(posedge px_clk);
    #1;
    cyc++;
    if (!rs) begin
      check("a_reset_word", a_if.strVGA, A_RST);
      check("a_reset_tick", a_if.frame_tick, 0);
      check("b_reset_word", b_if.strVGA, B_RST);
      check("b_reset_tick", b_if.frame_tick, 0);
      ax = 0; ay = 0; bx = 0; by = 0;
      last_a = A_RST; last_b = B_RST;
    end else begin
      if (ea) begin
        exp = word_a(ax, ay);
        check("a_word", a_if.strVGA, exp);
        check("a_tick", a_if.frame_tick, (ax == 799 && ay == 524) ? 1 : 0);
        if (a_if.strVGA[2]) a_act_cnt++;
        if (!a_if.strVGA[1]) a_hsl_cnt++;
        last_a = exp;
        ax++;
        if (ax == 800) begin ax = 0; ay++; if (ay == 525) ay = 0; end
      end else begin
        check("a_hold_word", a_if.strVGA, last_a);
        check("a_hold_tick", a_if.frame_tick, 0);
      end
      if (eb) begin
        exp = word_b(bx, by);
        check("b_word", b_if.strVGA, exp);
        check("b_tick", b_if.frame_tick, (bx == 15 && by == 10) ? 1 : 0);
        if (b_if.strVGA[2]) b_act_cnt++;
        if (!b_if.strVGA[0]) b_vsl_cnt++;
        if (b_if.frame_tick === 1'b1) begin
          b_ticks++;
          if (b_last_tick >= 0) check("b_tick_period", cyc - b_last_tick, 176);
          b_last_tick = cyc;
          check("b_vsync_words", b_vsl_cnt, 32);
          check("b_active_words", b_act_cnt, 48);
          b_vsl_cnt = 0;
          b_act_cnt = 0;
        end
        last_b = exp;
        bx++;
        if (bx == 16) begin bx = 0; by++; if (by == 11) by = 0; end
      end else begin
        check("b_hold_word", b_if.strVGA, last_b);
        check("b_hold_tick", b_if.frame_tick, 0);
      end
    end
  endtask

  initial begin
    a_if.enable = 1'b1;
    b_if.enable = 1'b0;

    // Reset held for 10 clocks with enable high: word must stay at the idle value.
    for (int i = 0; i < 10; i++) cycle();
    check("a_reset_hex", a_if.strVGA, 23'h000003);

    // Release; first enabled edge shows (0,0) visible with idle syncs.
    reset = 1'b1;
    cycle();
    check("a_first_word", a_if.strVGA, 23'h000007);

    // Rest of line 0, then tally visible and hsync-asserted words over the whole line.
    for (int i = 1; i < 800; i++) cycle();
    check("a_line_active", a_act_cnt, 640);
    check("a_line_hsync", a_hsl_cnt, 96);
    cycle();
    check("a_line_wrap", a_if.strVGA, 23'h00000F);

    // Advance until (300,2) is on the bus, then drop reset between clock edges.
    for (int i = 0; i < 5000 && !(ax == 301 && ay == 2); i++) cycle();
    check("a_at_300_2", a_if.strVGA, 23'h258017);
    #2;
    reset = 1'b0;
    #1;
    check("a_async_word", a_if.strVGA, 23'h000003);
    check("a_async_tick", a_if.frame_tick, 0);
    check("b_async_word", b_if.strVGA, 23'h000001);
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1;
    cycle();
    check("a_restart", a_if.strVGA, 23'h000007);

    // Stall at (100,10) for 50 clocks, then resume at (101,10).
    for (int i = 0; i < 10000 && !(ax == 101 && ay == 10); i++) cycle();
    check("a_at_100_10", a_if.strVGA, 23'h0C8057);
    a_if.enable = 1'b0;
    for (int i = 0; i < 50; i++) cycle();
    check("a_stall_word", a_if.strVGA, 23'h0C8057);
    a_if.enable = 1'b1;
    cycle();
    check("a_resume", a_if.strVGA, 23'h0CA057);

    // Reduced raster: two full frames up to the second tick.
    a_if.enable = 1'b0;
    b_if.enable = 1'b1;
    cycle();
    check("b_first_word", b_if.strVGA, 23'h000005);
    for (int i = 0; i < 1000 && b_ticks < 2; i++) cycle();
    check("b_tick_count", b_ticks, 2);
    check("b_last_word", b_if.strVGA, 23'h01E051);

    // Stall on the last pixel: word frozen, no repeated tick; resume wraps to (0,0).
    b_if.enable = 1'b0;
    for (int i = 0; i < 50; i++) cycle();
    check("b_stall_word", b_if.strVGA, 23'h01E051);
    b_if.enable = 1'b1;
    cycle();
    check("b_frame_wrap", b_if.strVGA, 23'h000005);
    check("b_wrap_tick", b_if.frame_tick, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
